// File: rtl/riscv_trace_pkg.sv
// riscv_trace_pkg: shared event types and control-nop encoding for the trace monitor
package riscv_trace_pkg;
  typedef enum logic [1:0] {EVT_EXIT = 2'd0, EVT_REPORT = 2'd1, EVT_PUTC = 2'd2} evt_type_e;
  localparam int K_EXIT_DEF = 1;
  localparam int K_REPORT_DEF = 2;
  localparam int K_PUTC_DEF = 4;
  function automatic logic [31:0] ctrl_insn(input int k);
    return {k[11:0], 5'd0, 3'b000, 5'd0, 7'h13};
  endfunction
endpackage

// File: rtl/riscv_trace_core_slice.sv
// riscv_trace_core_slice: per-core x3 shadow, control-nop decode, RUN/TERM FSM and 1-entry event slot
module riscv_trace_core_slice
  import riscv_trace_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int K_EXIT = K_EXIT_DEF,
  parameter int K_REPORT = K_REPORT_DEF,
  parameter int K_PUTC = K_PUTC_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            valid,
  input  logic [31:0]     insn,
  input  logic            wben,
  input  logic [4:0]      wbreg,
  input  logic [XLEN-1:0] wbdata,
  input  logic            drain,
  output logic            full,
  output evt_type_e       slot_type,
  output logic [XLEN-1:0] slot_data,
  output logic            term,
  output logic [XLEN-1:0] exit_code,
  output logic            overflow
);
  typedef enum logic {RUN, TERM} state_e;
  state_e state, state_nx;
  logic [XLEN-1:0] x3;
  logic run, is_exit, is_rep, is_putc, evt, load, drop;
  evt_type_e evt_t;
  assign run = state == RUN;
  assign is_exit = run & valid & (insn == ctrl_insn(K_EXIT));
  assign is_rep = run & valid & (insn == ctrl_insn(K_REPORT));
  assign is_putc = run & valid & (insn == ctrl_insn(K_PUTC));
  assign evt = is_exit | is_rep | is_putc;
  assign evt_t = is_exit ? EVT_EXIT : is_rep ? EVT_REPORT : EVT_PUTC;
  // an exit always lands in the slot; other events only if it is free or draining now
  assign load = evt & (!full | drain | is_exit);
  assign drop = evt & full & !drain;
  assign term = state == TERM;
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= RUN;
    else state <= state_nx;
  // next state: the first exit retirement terminates the core for good
  always_comb begin
    state_nx = state;
    if (is_exit) state_nx = TERM;
  end
  // x3 shadow, event slot, overflow and exit code capture
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      x3 <= '0;
      full <= 1'b0;
      slot_type <= EVT_EXIT;
      slot_data <= '0;
      overflow <= 1'b0;
      exit_code <= '0;
    end else begin
      if (run & valid & wben & (wbreg == 5'd3)) x3 <= wbdata;
      if (load) begin
        full <= 1'b1;
        slot_type <= evt_t;
        slot_data <= x3;
      end else if (drain) full <= 1'b0;
      if (drop) overflow <= 1'b1;
      if (is_exit) exit_code <= x3;
    end
endmodule

// File: rtl/riscv_trace_event_monitor.sv
// riscv_trace_event_monitor: multi-core trace monitor with RR event stream, termination, cycle counter and timeout
module riscv_trace_event_monitor
  import riscv_trace_pkg::*;
#(
  parameter int NUM_CORES = 8,
  parameter int XLEN = 32,
  parameter int CNT_W = 48,
  parameter longint unsigned TIMEOUT_CYCLES = 0,
  parameter int K_EXIT = K_EXIT_DEF,
  parameter int K_REPORT = K_REPORT_DEF,
  parameter int K_PUTC = K_PUTC_DEF,
  localparam int CW = NUM_CORES > 1 ? $clog2(NUM_CORES) : 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_CORES-1:0]      trace_valid,
  input  logic [NUM_CORES*32-1:0]   trace_insn,
  input  logic [NUM_CORES-1:0]      trace_wben,
  input  logic [NUM_CORES*5-1:0]    trace_wbreg,
  input  logic [NUM_CORES*XLEN-1:0] trace_wbdata,
  output logic                      evt_valid,
  input  logic                      evt_ready,
  output logic [CW-1:0]             evt_core,
  output logic [1:0]                evt_type,
  output logic [XLEN-1:0]           evt_data,
  output logic [NUM_CORES-1:0]      termination,
  output logic [NUM_CORES*XLEN-1:0] exit_code,
  output logic                      all_terminated,
  output logic [NUM_CORES-1:0]      overflow,
  output logic [CNT_W-1:0]          cycle_count,
  output logic                      timeout
);
  logic [NUM_CORES-1:0] full, drain;
  evt_type_e st [NUM_CORES];
  logic [XLEN-1:0] sd [NUM_CORES];
  logic [CW-1:0] ptr, lidx, pick, grant;
  logic [CW:0] idx;
  logic locked, found, hs, hit, timeout_q;
  for (genvar g = 0; g < NUM_CORES; g++) begin : g_core
    riscv_trace_core_slice #(.XLEN(XLEN), .K_EXIT(K_EXIT), .K_REPORT(K_REPORT), .K_PUTC(K_PUTC)) u_slice (
      .clk(clk), .rst_n(rst_n),
      .valid(trace_valid[g]), .insn(trace_insn[g*32+:32]), .wben(trace_wben[g]),
      .wbreg(trace_wbreg[g*5+:5]), .wbdata(trace_wbdata[g*XLEN+:XLEN]),
      .drain(drain[g]), .full(full[g]), .slot_type(st[g]), .slot_data(sd[g]),
      .term(termination[g]), .exit_code(exit_code[g*XLEN+:XLEN]), .overflow(overflow[g])
    );
  end
  // round-robin search for the first full slot starting at the priority pointer
  always_comb begin
    pick = ptr;
    found = 1'b0;
    idx = '0;
    for (int k = 0; k < NUM_CORES; k++) begin
      idx = {1'b0, ptr} + (CW+1)'(k);
      idx = idx >= (CW+1)'(NUM_CORES) ? idx - (CW+1)'(NUM_CORES) : idx;
      if (!found && full[idx[CW-1:0]]) begin
        found = 1'b1;
        pick = idx[CW-1:0];
      end
    end
  end
  // a stalled grant stays locked so a newly filled slot cannot change the outputs
  assign grant = locked ? lidx : pick;
  assign evt_valid = |full;
  assign evt_core = grant;
  assign evt_type = st[grant];
  assign evt_data = sd[grant];
  assign hs = evt_valid & evt_ready;
  assign drain = hs ? NUM_CORES'(1) << grant : '0;
  assign hit = rst_n && (TIMEOUT_CYCLES != 0) && !all_terminated && (cycle_count == CNT_W'(TIMEOUT_CYCLES - 1));
  assign timeout = timeout_q | hit;
  // arbiter pointer/lock, termination summary, cycle counter and sticky timeout
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      ptr <= '0;
      locked <= 1'b0;
      lidx <= '0;
      all_terminated <= 1'b0;
      cycle_count <= '0;
      timeout_q <= 1'b0;
    end else begin
      if (hs) ptr <= grant == CW'(NUM_CORES - 1) ? '0 : grant + 1'b1;
      locked <= evt_valid & !evt_ready;
      lidx <= grant;
      all_terminated <= &termination;
      if (!all_terminated && cycle_count != '1) cycle_count <= cycle_count + 1'b1;
      timeout_q <= timeout_q | hit;
    end
endmodule

// File: tb/tb_riscv_trace_event_monitor.sv
// tb_riscv_trace_event_monitor: behavioural-model scoreboard plus directed literal checks
module tb_riscv_trace_event_monitor;
  localparam logic [31:0] EXIT_I = 32'h0010_0013;
  localparam logic [31:0] REP_I  = 32'h0020_0013;
  localparam logic [31:0] PUTC_I = 32'h0040_0013;
  localparam logic [31:0] ADDI_X3 = 32'h0000_0193;
  logic clk, rst_n, rst1_n, evt_ready;
  logic [7:0] trace_valid, trace_wben;
  logic [255:0] trace_insn, trace_wbdata;
  logic [39:0] trace_wbreg;
  logic evt_valid, all_terminated, timeout;
  logic [2:0] evt_core;
  logic [1:0] evt_type;
  logic [31:0] evt_data;
  logic [7:0] termination, overflow;
  logic [255:0] exit_code;
  logic [47:0] cycle_count;
  logic evt_valid1, all_terminated1, timeout1;
  logic [2:0] evt_core1;
  logic [1:0] evt_type1;
  logic [31:0] evt_data1;
  logic [7:0] termination1, overflow1;
  logic [255:0] exit_code1;
  logic [47:0] cycle_count1;
  int checks = 0, errors = 0;

  riscv_trace_event_monitor dut (
    .clk(clk), .rst_n(rst_n), .trace_valid(trace_valid), .trace_insn(trace_insn),
    .trace_wben(trace_wben), .trace_wbreg(trace_wbreg), .trace_wbdata(trace_wbdata),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_core(evt_core), .evt_type(evt_type),
    .evt_data(evt_data), .termination(termination), .exit_code(exit_code),
    .all_terminated(all_terminated), .overflow(overflow), .cycle_count(cycle_count), .timeout(timeout)
  );

  riscv_trace_event_monitor #(.TIMEOUT_CYCLES(50)) dut_to (
    .clk(clk), .rst_n(rst1_n), .trace_valid(8'h00), .trace_insn(256'h0),
    .trace_wben(8'h00), .trace_wbreg(40'h0), .trace_wbdata(256'h0),
    .evt_valid(evt_valid1), .evt_ready(1'b0), .evt_core(evt_core1), .evt_type(evt_type1),
    .evt_data(evt_data1), .termination(termination1), .exit_code(exit_code1),
    .all_terminated(all_terminated1), .overflow(overflow1), .cycle_count(cycle_count1), .timeout(timeout1)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", n, act, exp);
    end
  endtask

  // behavioural model: per-core shadow, terminated flag, single pending event, sticky drop flag
  int m_sh [8], m_ex [8], m_type [8], m_data [8];
  bit m_term [8], m_full [8], m_ovf [8];
  int m_ptr, m_lidx;
  bit m_lock, m_allt, m_to1;
  longint unsigned m_cnt, m_cnt1;

  function automatic int shown();
    if (m_lock) return m_lidx;
    for (int k = 0; k < 8; k++) if (m_full[(m_ptr + k) % 8]) return (m_ptr + k) % 8;
    return 0;
  endfunction

  function automatic bit any_full();
    for (int c = 0; c < 8; c++) if (m_full[c]) return 1;
    return 0;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < 8; c++) begin
        m_sh[c] = 0; m_ex[c] = 0; m_type[c] = 0; m_data[c] = 0;
        m_term[c] = 0; m_full[c] = 0; m_ovf[c] = 0;
      end
      m_ptr = 0; m_lidx = 0; m_lock = 0; m_allt = 0; m_cnt = 0;
    end else begin
      automatic int g = shown();
      automatic bit any = any_full();
      automatic bit hs = any && evt_ready;
      automatic bit every = 1;
      for (int c = 0; c < 8; c++) every &= m_term[c];
      for (int c = 0; c < 8; c++) begin
        automatic int kind = -1;
        automatic logic [31:0] ins = trace_insn[c*32+:32];
        if (hs && g == c) m_full[c] = 0;
        if (!m_term[c] && trace_valid[c]) begin
          kind = ins == EXIT_I ? 0 : ins == REP_I ? 1 : ins == PUTC_I ? 2 : -1;
          if (kind >= 0) begin
            if (m_full[c]) m_ovf[c] = 1;
            if (!m_full[c] || kind == 0) begin
              m_full[c] = 1; m_type[c] = kind; m_data[c] = m_sh[c];
            end
          end
          if (trace_wben[c] && trace_wbreg[c*5+:5] == 5'd3) m_sh[c] = trace_wbdata[c*32+:32];
          if (kind == 0) begin
            m_term[c] = 1; m_ex[c] = m_data[c];
          end
        end
      end
      m_lock = any && !evt_ready;
      m_lidx = g;
      if (hs) m_ptr = (g + 1) % 8;
      if (!m_allt && m_cnt != 48'hFFFF_FFFF_FFFF) m_cnt++;
      m_allt = every;
    end
  end

  always @(posedge clk or negedge rst1_n) begin
    if (!rst1_n) begin
      m_cnt1 = 0; m_to1 = 0;
    end else begin
      if (m_cnt1 == 49) m_to1 = 1;
      m_cnt1++;
    end
  end

  // compare process: every cycle out of reset
  always @(negedge clk) begin
    if (rst_n) begin
      automatic logic [7:0] t = '0, o = '0;
      automatic int g = shown();
      for (int c = 0; c < 8; c++) begin
        t[c] = m_term[c]; o[c] = m_ovf[c];
        chk($sformatf("exit_code[%0d]", c), 64'(exit_code[c*32+:32]), 64'(32'(m_ex[c])));
      end
      chk("evt_valid", 64'(evt_valid), 64'(any_full()));
      if (any_full()) begin
        chk("evt_core", 64'(evt_core), 64'(g));
        chk("evt_type", 64'(evt_type), 64'(m_type[g]));
        chk("evt_data", 64'(evt_data), 64'(32'(m_data[g])));
      end
      chk("termination", 64'(termination), 64'(t));
      chk("overflow", 64'(overflow), 64'(o));
      chk("all_terminated", 64'(all_terminated), 64'(m_allt));
      chk("cycle_count", 64'(cycle_count), 64'(m_cnt));
      chk("timeout_disabled", 64'(timeout), 64'(0));
    end
    if (rst1_n) begin
      chk("to_cycle_count", 64'(cycle_count1), 64'(m_cnt1));
      chk("to_timeout", 64'(timeout1), 64'(m_to1 || m_cnt1 == 49));
    end
  end

  task automatic clr();
    trace_valid = '0; trace_wben = '0; trace_insn = '0; trace_wbreg = '0; trace_wbdata = '0;
  endtask
  task automatic step(input int n = 1);
    repeat (n) @(negedge clk);
    clr();
  endtask
  task automatic wr(input int c, input logic [31:0] d);
    trace_valid[c] = 1; trace_wben[c] = 1; trace_insn[c*32+:32] = ADDI_X3;
    trace_wbreg[c*5+:5] = 5'd3; trace_wbdata[c*32+:32] = d;
  endtask
  task automatic nop(input int c, input logic [31:0] i);
    trace_valid[c] = 1; trace_insn[c*32+:32] = i;
  endtask
  task automatic do_reset();
    rst_n = 0;
    step();
    rst_n = 1;
  endtask

  initial begin
    logic [47:0] frozen;
    bit seen;
    clr();
    rst_n = 0; rst1_n = 0; evt_ready = 0;
    step(2);
    chk("rst evt_valid", 64'(evt_valid), 0);
    chk("rst termination", 64'(termination), 0);
    chk("rst cycle_count", 64'(cycle_count), 0);
    chk("rst outputs", 64'({all_terminated, timeout, overflow}), 0);
    rst_n = 1;
    step(5);
    chk("idle cycle_count", 64'(cycle_count), 5);
    // single putc from core 2
    wr(2, 32'h41);
    step();
    nop(2, PUTC_I); evt_ready = 1;
    step();
    chk("putc valid", 64'(evt_valid), 1);
    chk("putc event", 64'({evt_core, evt_type, evt_data}), 64'({3'd2, 2'd2, 32'h41}));
    step();
    chk("putc drained", 64'(evt_valid), 0);
    // all cores report together: core order from a fresh pointer
    do_reset();
    for (int c = 0; c < 8; c++) wr(c, 32'(c + 16));
    step();
    for (int c = 0; c < 8; c++) nop(c, REP_I);
    step();
    for (int k = 0; k < 8; k++) begin
      chk("burst event", 64'({evt_valid, evt_core, evt_type, evt_data}), 64'({1'b1, 3'(k), 2'd1, 32'(k + 16)}));
      step();
    end
    chk("burst end", 64'({evt_valid, overflow}), 0);
    // stalled consumer: putc dropped, report retained
    do_reset();
    evt_ready = 0;
    wr(1, 32'h55);
    step();
    nop(1, REP_I);
    step();
    nop(1, PUTC_I);
    step();
    chk("ovf flag", 64'(overflow), 64'h02);
    step(2);
    chk("held event", 64'({evt_valid, evt_core, evt_type, evt_data}), 64'({1'b1, 3'd1, 2'd1, 32'h55}));
    evt_ready = 1;
    step();
    chk("held drained", 64'(evt_valid), 0);
    // stalled consumer: exit overwrites the pending report
    evt_ready = 0;
    nop(1, REP_I);
    step();
    nop(1, EXIT_I);
    step();
    chk("exit overwrite", 64'({evt_valid, evt_core, evt_type, evt_data}), 64'({1'b1, 3'd1, 2'd0, 32'h55}));
    evt_ready = 1;
    step();
    chk("exit drained", 64'({evt_valid, termination}), 64'({1'b0, 8'h02}));
    // every core exits with code i, core 7 last
    do_reset();
    evt_ready = 1;
    for (int c = 0; c < 8; c++) begin
      wr(c, 32'(c));
      step();
      nop(c, EXIT_I);
      step();
      if (c == 6) chk("term pre-last", 64'({all_terminated, termination}), 64'({1'b0, 8'h7F}));
    end
    chk("term all", 64'({all_terminated, termination}), 64'({1'b0, 8'hFF}));
    for (int c = 0; c < 8; c++) chk("exit code", 64'(exit_code[c*32+:32]), 64'(c));
    step();
    chk("all_terminated", 64'(all_terminated), 1);
    frozen = cycle_count;
    for (int c = 0; c < 8; c++) begin
      wr(c, 32'hDEAD);
      step();
      nop(c, REP_I);
      step();
    end
    chk("frozen count", 64'(cycle_count), 64'(frozen));
    chk("ignored trace", 64'({evt_valid, overflow, exit_code[3*32+:32]}), 64'({1'b0, 8'h00, 32'd3}));
    // timeout instance
    rst1_n = 1;
    seen = 0;
    for (int i = 0; i < 200 && !seen; i++) begin
      step();
      if (cycle_count1 == 48) seen = 1;
    end
    chk("to reached 48", 64'(seen), 1);
    chk("to low at 48", 64'(timeout1), 0);
    step();
    chk("to high at 49", 64'({cycle_count1, timeout1}), 64'({48'd49, 1'b1}));
    step(5);
    chk("to sticky", 64'(timeout1), 1);
    #3 rst1_n = 0;
    #1 chk("to async clear", 64'({cycle_count1, timeout1}), 0);
    step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
